// File: rtl/instruction_fetch_unit.sv
// Fetch responder: turns a control-unit fetch request into one single-beat AXI4 read from ICCM.
// Zero-wait latency is 3 cycles from the sampled request to fetch_done; AR/R stalls add cycles one for one.
module instruction_fetch_unit #(
    parameter int               ID_W      = 4,
    parameter logic [ID_W-1:0]  AXI_ID    = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic [31:0]     fetch_address,
    output logic            fetch_done,
    output logic [31:0]     instruction,
    output logic            fetch_error,
    output logic            busy,
    output logic [31:0]     m_axi_araddr_iccm,
    output logic [1:0]      m_axi_arburst_iccm,
    output logic [ID_W-1:0] m_axi_arid_iccm,
    output logic [7:0]      m_axi_arlen_iccm,
    output logic [2:0]      m_axi_arsize_iccm,
    output logic            m_axi_arvalid_iccm,
    input  logic            m_axi_arready_iccm,
    input  logic [31:0]     m_axi_rdata_iccm,
    input  logic [ID_W-1:0] m_axi_rid_iccm,
    input  logic            m_axi_rlast_iccm,
    input  logic [1:0]      m_axi_rresp_iccm,
    input  logic            m_axi_rvalid_iccm,
    output logic            m_axi_rready_iccm
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;

    // Single-beat reads: RLAST carries no information here.
    logic unused_rlast;
    assign unused_rlast = m_axi_rlast_iccm;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (fetch_en) begin
                    addr_d = fetch_address;
                    if (fetch_address[1:0] != 2'b00) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        instr_d = NOP_INSTR;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (m_axi_arready_iccm) state_d = DATA;
            end
            DATA: begin
                if (m_axi_rvalid_iccm) begin
                    state_d = DONE;
                    if (m_axi_rresp_iccm == 2'b00 && m_axi_rid_iccm == AXI_ID) begin
                        instr_d = m_axi_rdata_iccm;
                        err_d   = 1'b0;
                    end else begin
                        instr_d = NOP_INSTR;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    assign fetch_done         = (state_q == DONE);
    assign fetch_error        = (state_q == DONE) && err_q;
    assign instruction        = instr_q;
    assign busy               = (state_q != IDLE);
    assign m_axi_araddr_iccm  = addr_q;
    assign m_axi_arvalid_iccm = (state_q == ADDR);
    assign m_axi_rready_iccm  = (state_q == DATA);
    assign m_axi_arburst_iccm = 2'b01;
    assign m_axi_arid_iccm    = AXI_ID;
    assign m_axi_arlen_iccm   = 8'd0;
    assign m_axi_arsize_iccm  = 3'b010;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Responder side of the control unit's fetch handshake. It accepts a fetch request (`fetch_en` plus `fetch_address`) and performs a single-beat AXI4 read from instruction memory (ICCM). It then returns the 32-bit instruction with a one-cycle `fetch_done` pulse. It sits between the control unit FSM and the ICCM AXI slave port.

## Interface
Parameters:
- `ID_W`, 4: width of AXI ID fields.
- `AXI_ID`, 0: constant ARID driven on every read; expected RID.
- `NOP_INSTR`, 32'h0000_0013: value loaded into `instruction` on any error.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_en`  in  1  request from control unit; level, sampled only in IDLE.
- `fetch_address`  in  32  byte address of the instruction; captured with the request.
- `fetch_done`  out  1  one-cycle pulse: `instruction`/`fetch_error` valid.
- `instruction`  out  32  fetched word; held until the next completion.
- `fetch_error`  out  1  valid with `fetch_done`: misaligned address, bad RRESP or RID mismatch.
- `busy`  out  1  high in every state except IDLE.
- `m_axi_araddr_iccm`  out  32  read address.
- `m_axi_arburst_iccm`  out  2  constant 2'b01 (INCR).
- `m_axi_arid_iccm`  out  ID_W  constant `AXI_ID`.
- `m_axi_arlen_iccm`  out  8  constant 0 (single beat).
- `m_axi_arsize_iccm`  out  3  constant 3'b010 (4 bytes).
- `m_axi_arvalid_iccm`  out  1  read address valid.
- `m_axi_arready_iccm`  in  1  read address ready.
- `m_axi_rdata_iccm`  in  32  read data.
- `m_axi_rid_iccm`  in  ID_W  read ID.
- `m_axi_rlast_iccm`  in  1  read last; ignored (single beat).
- `m_axi_rresp_iccm`  in  2  read response.
- `m_axi_rvalid_iccm`  in  1  read data valid.
- `m_axi_rready_iccm`  out  1  read ready.

## Operation
The FSM has four states: IDLE, ADDR, DATA, DONE.
- IDLE: on `fetch_en=1`, register `fetch_address` into `addr_q`.
  - If `fetch_address[1:0]!=0`: go to DONE with the error flag set; no bus access.
  - Otherwise go to ADDR.
- ADDR: `arvalid=1`, `araddr=addr_q`. Hold both stable until `arready=1`, then go to DATA.
- DATA: `rready=1`. On `rvalid=1`:
  - If `rresp==2'b00` and `rid==AXI_ID`: load `instruction<=rdata` and clear the error flag.
  - Otherwise: load `instruction<=NOP_INSTR` and set the error flag.
  - Go to DONE in either case.
- DONE: `fetch_done=1` for exactly one cycle; `fetch_error` equals the error flag. Go to IDLE.
- A misaligned request also loads `instruction<=NOP_INSTR`, written on the IDLE→DONE transition.
- `fetch_en` and `fetch_address` are ignored outside IDLE. A new request is accepted on the cycle the FSM is back in IDLE.
- `addr_q` is unchanged by later `fetch_address` changes during a transaction.

## Timing
- Reset values:
  - FSM: IDLE.
  - Outputs: `fetch_done=0`, `fetch_error=0`, `instruction=0`, `busy=0`, `arvalid=0`, `rready=0`, `araddr=0`.
- Constant AXI fields are driven at all times, including during reset.
- Zero-wait memory: `fetch_en` sampled at edge N → `arvalid` high in cycle N+1 → `rready` high in cycle N+2 → `fetch_done` in cycle N+3.
- Each cycle of `arready` or `rvalid` stall adds one cycle.
- Misaligned request: `fetch_done` in cycle N+1.
- `fetch_en` held high continuously: one fetch every 4 cycles at zero wait.
- `arvalid` never deasserts before `arready`. `rready` is high only in DATA. Only one outstanding read at a time.
- `rvalid` arriving during ADDR has no effect; it is not possible under AXI ordering.
- `fetch_error` and `instruction` change only on transitions into DONE. `fetch_error` is 0 whenever `fetch_done=0`.
- Reset asserted in any state: next cycle the FSM is IDLE and all outputs are at reset values.
  - An in-flight AXI read is abandoned; the ICCM shares this reset.

## Test plan
- Aligned fetch, zero-wait slave: `fetch_address=0x100`, rdata `0x00A00093`, rresp OKAY → `araddr=0x100`, `fetch_done` 3 cycles after request, `instruction=0x00A00093`, `fetch_error=0`.
- Stalls: `arready` delayed 2 cycles and `rvalid` delayed 3 cycles → `araddr` and `arvalid` stable throughout, `fetch_done` at cycle 8, exactly one AR handshake.
- Misaligned: `fetch_address=0x102` → no `arvalid`, `fetch_done` next cycle, `fetch_error=1`, `instruction=0x00000013`.
- Bus error: rresp=2'b10 (SLVERR), then separately RID≠`AXI_ID` → `fetch_error=1`, `instruction=0x00000013`.
- Back-to-back: `fetch_en` held high with addresses 0x0, 0x4, 0x8 → three `fetch_done` pulses 4 cycles apart, correct data each. An address change mid-transaction does not alter `araddr`.
- Reset mid-transaction: assert `reset` in DATA → next cycle `rready=0`, `busy=0`, no `fetch_done`. A subsequent fetch to 0x4 completes normally.
